// File: rtl/tetris_collision_reader.sv
// Playfield collision probe: bounds-checks four candidate cells, then reads each from SRAM
// and flags the first one that is occupied.
module tetris_collision_reader #(
    parameter int          FIELD_W     = 10,
    parameter int          FIELD_H     = 22,
    parameter logic [15:0] EMPTY_COLOR = 16'h0FFF,
    parameter int          READ_LAT    = 1
) (
    input  logic        VGA_CTRL_CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [19:0] cells_x,
    input  logic [19:0] cells_y,
    output logic        busy,
    output logic        done,
    output logic        collide,
    output logic        out_of_bounds,
    output logic [1:0]  hit_index,
    output logic        rd_req,
    input  logic        rd_gnt,
    output logic [17:0] sram_addr,
    input  logic [15:0] sram_dq
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] BOUNDS = 3'd1;
    localparam logic [2:0] REQ    = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] SAMPLE = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) + 1 : 1;

    logic [2:0]    state;
    logic [4:0]    cx [4];
    logic [4:0]    cy [4];
    logic [1:0]    idx;
    logic [LW-1:0] lat_cnt;
    logic [3:0]    oob_vec;
    logic [1:0]    oob_idx;

    always_comb begin
        oob_vec = '0;
        oob_idx = 2'd0;
        for (int i = 0; i < 4; i++)
            oob_vec[i] = (cx[i] >= 5'(FIELD_W)) || (cy[i] >= 5'(FIELD_H));
        // Descending scan so the lowest offending index wins.
        for (int i = 3; i >= 0; i--)
            if (oob_vec[i]) oob_idx = 2'(i);
    end

    assign busy      = (state == BOUNDS) || (state == REQ) || (state == WAIT) || (state == SAMPLE);
    assign done      = (state == DONE);
    assign rd_req    = (state == REQ) || (state == WAIT) || (state == SAMPLE);
    assign sram_addr = rd_req ? {cx[idx], cy[idx], 8'b0} : 18'd0;

    always_ff @(posedge VGA_CTRL_CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            idx           <= 2'd0;
            lat_cnt       <= '0;
            collide       <= 1'b0;
            out_of_bounds <= 1'b0;
            hit_index     <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                cx[i] <= 5'd0;
                cy[i] <= 5'd0;
            end
        end else begin
            case (state)
                IDLE: if (start) begin
                    for (int i = 0; i < 4; i++) begin
                        cx[i] <= cells_x[5*i +: 5];
                        cy[i] <= cells_y[5*i +: 5];
                    end
                    collide       <= 1'b0;
                    out_of_bounds <= 1'b0;
                    hit_index     <= 2'd0;
                    state         <= BOUNDS;
                end
                BOUNDS: if (|oob_vec) begin
                    out_of_bounds <= 1'b1;
                    collide       <= 1'b1;
                    hit_index     <= oob_idx;
                    state         <= DONE;
                end else begin
                    idx   <= 2'd0;
                    state <= REQ;
                end
                REQ: if (rd_gnt) begin
                    lat_cnt <= LW'(READ_LAT - 1);
                    state   <= (READ_LAT <= 1) ? SAMPLE : WAIT;
                end
                WAIT: if (!rd_gnt) begin
                    state <= REQ;
                end else begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt <= LW'(1)) state <= SAMPLE;
                end
                SAMPLE: if (!rd_gnt) begin
                    // Bus lost mid-read: the word on sram_dq is not ours, re-request.
                    state <= REQ;
                end else if (sram_dq != EMPTY_COLOR) begin
                    collide   <= 1'b1;
                    hit_index <= idx;
                    state     <= DONE;
                end else if (idx == 2'd3) begin
                    state <= DONE;
                end else begin
                    idx   <= idx + 2'd1;
                    state <= REQ;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_collision_reader.sv
// Directed bench for tetris_collision_reader: cycle-accurate latency, addresses and results
// against hand-computed values, with a one-cell occupancy SRAM model.
module tb_tetris_collision_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [19:0] cells_x, cells_y;
    logic        busy, done, collide, oob, rd_req, rd_gnt;
    logic [1:0]  hit_index;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq;

    logic        occ_en;
    logic [17:0] occ_addr;

    int total = 0;
    int fails = 0;
    int cyc, dcyc, nreads, req_seen, done_seen;
    logic [17:0] addrs [16];

    always #5 clk = ~clk;

    assign sram_dq = (occ_en && sram_addr == occ_addr) ? 16'h00FF : 16'h0FFF;

    tetris_collision_reader dut (
        .VGA_CTRL_CLK (clk),
        .RST          (rst_n),
        .start        (start),
        .cells_x      (cells_x),
        .cells_y      (cells_y),
        .busy         (busy),
        .done         (done),
        .collide      (collide),
        .out_of_bounds(oob),
        .hit_index    (hit_index),
        .rd_req       (rd_req),
        .rd_gnt       (rd_gnt),
        .sram_addr    (sram_addr),
        .sram_dq      (sram_dq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cells(input logic [4:0] x0, y0, x1, y1, x2, y2, x3, y3);
        cells_x = {x3, x2, x1, x0};
        cells_y = {y3, y2, y1, y0};
    endtask

    // Called at a negedge; start is high for this cycle (cycle 0). Returns in the done cycle,
    // or right after asserting reset when rc is reached.
    task automatic run(input int xs, input int gf, input int rc);
        nreads = 0; dcyc = -1; req_seen = 0; cyc = 0;
        rd_gnt = (gf <= 0);
        start  = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            cyc++;
            start  = (cyc == xs);
            rd_gnt = (cyc >= gf);
            if (cyc == rc) begin
                #1 rst_n = 1'b0;
                #1;
                start = 1'b0;
                return;
            end
            if (rd_req) begin
                req_seen = 1;
                if ((nreads == 0 || sram_addr != addrs[nreads-1]) && nreads < 16) begin
                    addrs[nreads] = sram_addr;
                    nreads++;
                end
            end
            if (done) begin
                dcyc  = cyc;
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; rd_gnt = 1'b0; occ_en = 1'b0; occ_addr = '0;
        cells_x = '0; cells_y = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_collide", collide, 0);
        chk("rst_oob", oob, 0);
        chk("rst_hit", hit_index, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_addr", sram_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: free path, all empty
        set_cells(4, 2, 4, 3, 4, 4, 4, 5);
        run(-1, 0, -1);
        chk("t1_done_cyc", dcyc, 10);
        chk("t1_busy_at_done", busy, 0);
        chk("t1_collide", collide, 0);
        chk("t1_oob", oob, 0);
        chk("t1_nreads", nreads, 4);
        chk("t1_addr0", addrs[0], 18'h08200);
        chk("t1_addr1", addrs[1], 18'h08300);
        chk("t1_addr2", addrs[2], 18'h08400);
        chk("t1_addr3", addrs[3], 18'h08500);
        @(negedge clk);
        chk("t1_idle_addr", sram_addr, 0);
        chk("t1_done_pulse", done, 0);
        chk("t1_collide_held", collide, 0);

        // 2: cell (4,4) occupied
        occ_en = 1'b1; occ_addr = 18'h08400;
        run(-1, 0, -1);
        chk("t2_done_cyc", dcyc, 8);
        chk("t2_collide", collide, 1);
        chk("t2_oob", oob, 0);
        chk("t2_hit", hit_index, 2);
        chk("t2_nreads", nreads, 3);
        @(negedge clk);
        chk("t2_collide_held", collide, 1);
        occ_en = 1'b0;

        // 3: cell 1 at x=10 out of bounds
        set_cells(9, 5, 10, 5, 8, 5, 8, 6);
        run(-1, 0, -1);
        chk("t3_done_cyc", dcyc, 2);
        chk("t3_collide", collide, 1);
        chk("t3_oob", oob, 1);
        chk("t3_hit", hit_index, 1);
        chk("t3_no_req", req_seen, 0);
        @(negedge clk);

        // 4: grant withheld for cycles 2..6
        set_cells(4, 2, 4, 3, 4, 4, 4, 5);
        run(-1, 7, -1);
        chk("t4_done_cyc", dcyc, 15);
        chk("t4_nreads", nreads, 4);
        chk("t4_addr0", addrs[0], 18'h08200);
        chk("t4_addr3", addrs[3], 18'h08500);
        chk("t4_collide", collide, 0);
        chk("t4_oob", oob, 0);
        @(negedge clk);

        // 5: start while busy ignored, start in DONE ignored, start after DONE accepted
        run(4, 0, -1);
        chk("t5_done_cyc", dcyc, 10);
        chk("t5_collide", collide, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_done_start_busy", busy, 0);
        chk("t5_single_done", done, 0);
        run(-1, 0, -1);
        chk("t5_after_done_cyc", dcyc, 10);
        @(negedge clk);

        // 6: reset during cell-2 SAMPLE aborts
        run(-1, 0, 7);
        chk("t6_rd_req", rd_req, 0);
        chk("t6_busy", busy, 0);
        chk("t6_addr", sram_addr, 0);
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) done_seen = 1;
        end
        chk("t6_no_done", done_seen, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run(-1, 0, -1);
        chk("t6_fresh_cyc", dcyc, 10);
        chk("t6_fresh_collide", collide, 0);
        @(negedge clk);

        // 7: x=31 wrap on cell 0
        set_cells(31, 0, 0, 0, 0, 0, 0, 0);
        run(-1, 0, -1);
        chk("t7_oob", oob, 1);
        chk("t7_hit", hit_index, 0);
        chk("t7_done_cyc", dcyc, 2);
        @(negedge clk);

        // 8: corners in range, only y=22 on cell 3 is out
        set_cells(9, 21, 0, 0, 9, 0, 0, 22);
        run(-1, 0, -1);
        chk("t8_oob", oob, 1);
        chk("t8_hit", hit_index, 3);
        chk("t8_no_req", req_seen, 0);
        @(negedge clk);

        // 9: corners (9,21) and (0,0) all in range and empty
        set_cells(9, 21, 0, 0, 9, 0, 0, 21);
        run(-1, 0, -1);
        chk("t9_collide", collide, 0);
        chk("t9_addr0", addrs[0], 18'h13500);
        chk("t9_done_cyc", dcyc, 10);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
